// File: rtl/hi_lo_unit_scheduler.sv
// Start/latency/strobe sequencer for the multi-cycle HI/LO multiply/divide unit.
// Optional macro EARLY_HILO_RELEASE_EN: MFHI/MFLO/MTHI/MTLO do not stall in DONE.
module hi_lo_unit_scheduler #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic mult_request_execute,
  input  logic div_request_execute,
  input  logic hi_lo_read_decode,
  input  logic hi_lo_write_direct_decode,
  input  logic flush_execute,
  input  logic abort,
  output logic unit_start,
  output logic unit_select_div,
  output logic hi_lo_register_write_unit,
  output logic stall_pipeline,
  output logic busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic             request;
  logic             any_dep;
  logic             hi_lo_dep;

  assign request = mult_request_execute | div_request_execute;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                     <= IDLE;
      counter                   <= '0;
      unit_start                <= 1'b0;
      unit_select_div           <= 1'b0;
      hi_lo_register_write_unit <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      unit_start                <= 1'b0;
      hi_lo_register_write_unit <= 1'b0;
      case (state)
        IDLE: begin
          if (request && !flush_execute && !abort) begin
            state           <= RUN;
            busy            <= 1'b1;
            unit_start      <= 1'b1;
            unit_select_div <= div_request_execute;
            counter         <= div_request_execute ? DivLoad : MultLoad;
          end
        end
        RUN: begin
          // Abort wins over expiry so a cancelled operation never writes HI/LO.
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else if (counter == '0) begin
            state                     <= DONE;
            hi_lo_register_write_unit <= 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          counter <= '0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

  assign hi_lo_dep = hi_lo_read_decode | hi_lo_write_direct_decode;
  assign any_dep   = hi_lo_dep | request;

`ifdef EARLY_HILO_RELEASE_EN
  // In DONE the forwarding path covers HI/LO readers and writers.
  assign stall_pipeline = busy & ((state == DONE) ? request : any_dep);
`else
  assign stall_pipeline = busy & any_dep;
`endif

endmodule

// File: tb/tb_hi_lo_unit_scheduler.sv
// Randomized scoreboard bench for hi_lo_unit_scheduler; model schedules events by cycle number.
module tb_hi_lo_unit_scheduler;

  localparam int MC = 4;
  localparam int DC = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mreq = 1'b0, dreq = 1'b0, rd = 1'b0, wd = 1'b0, flush = 1'b0, abort = 1'b0;
  logic unit_start, unit_select_div, hi_lo_register_write_unit, stall_pipeline, busy;

  hi_lo_unit_scheduler #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC),
    .CNT_W      (6)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .mult_request_execute     (mreq),
    .div_request_execute      (dreq),
    .hi_lo_read_decode        (rd),
    .hi_lo_write_direct_decode(wd),
    .flush_execute            (flush),
    .abort                    (abort),
    .unit_start               (unit_start),
    .unit_select_div          (unit_select_div),
    .hi_lo_register_write_unit(hi_lo_register_write_unit),
    .stall_pipeline           (stall_pipeline),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic start;
    logic sel;
    logic sel_chk;
    logic wr;
    logic busy;
    logic stall;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: outputs are presented every cycle and compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("unit_start", unit_start, e.start);
      chk("write_strobe", hi_lo_register_write_unit, e.wr);
      chk("busy", busy, e.busy);
      chk("stall_pipeline", stall_pipeline, e.stall);
      if (e.sel_chk) chk("unit_select_div", unit_select_div, e.sel);
    end
  end

  // Reference model: an accepted operation is a schedule of absolute cycle numbers.
  int   start_c = -1, wr_c = -1, idle_c = -1;
  logic last_div = 1'b0;
  int   t = 0;
  bit   did_reset = 0;

  function automatic logic busy_at(input int c);
    return (c >= start_c) && (c < idle_c);
  endfunction

  task automatic push_expected();
    exp_t e;
    logic b, done, anyd;
    b    = busy_at(t);
    done = (t == wr_c);
    anyd = rd | wd | mreq | dreq;
    e.start   = (t == start_c);
    e.wr      = done;
    e.busy    = b;
    e.sel     = last_div;
    e.sel_chk = b;
`ifdef EARLY_HILO_RELEASE_EN
    e.stall = b & (done ? (mreq | dreq) : anyd);
`else
    e.stall = b & anyd;
`endif
    q.push_back(e);
  endtask

  task automatic push_zero();
    exp_t e;
    e = '0;
    q.push_back(e);
  endtask

  task automatic advance_model();
    int n;
    if (!busy_at(t) && (mreq | dreq) && !flush && !abort) begin
      n        = dreq ? DC : MC;
      start_c  = t + 1;
      wr_c     = t + n + 1;
      idle_c   = t + n + 2;
      last_div = dreq;
    end else if (busy_at(t) && abort) begin
      idle_c = t + 1;
      if (wr_c > t) wr_c = -1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_start", unit_start, 1'b0);
    chk("reset_sel", unit_select_div, 1'b0);
    chk("reset_wr", hi_lo_register_write_unit, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stall", stall_pipeline, 1'b0);
    reset = 1'b1;

    while (t < 4000) begin
      if (t >= 2000 && !did_reset && busy_at(t) && t > start_c && t < wr_c) begin
        did_reset = 1;
        {mreq, dreq, rd, wd, flush, abort} = '0;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_start", unit_start, 1'b0);
        chk("async_reset_wr", hi_lo_register_write_unit, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_stall", stall_pipeline, 1'b0);
        chk("async_reset_sel", unit_select_div, 1'b0);
        push_zero();
        start_c = -1; wr_c = -1; idle_c = -1; last_div = 1'b0;
        @(posedge clk); #1; t++;
        push_zero();
        @(posedge clk); #1; t++;
        reset = 1'b1;
        // First post-reset cycle: a plain multiply must finish on schedule.
        {rd, wd, flush, abort, dreq} = '0;
        mreq = 1'b1;
      end else begin
        mreq  = ($urandom_range(0, 7) == 0);
        dreq  = ($urandom_range(0, 15) == 0);
        rd    = ($urandom_range(0, 3) == 0);
        wd    = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 39) == 0);
      end
      push_expected();
      advance_model();
      @(posedge clk); #1; t++;
    end

    {mreq, dreq, rd, wd, flush, abort} = '0;
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q.size());
    end
    checks++;
    if (!did_reset) begin
      failures++;
      $display("FAIL async_reset_reached: actual=0 required=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hi_lo_unit_scheduler.md
Name: hi_lo_unit_scheduler

Overview:
- Sequences the multi-cycle multiply/divide unit that produces the HI/LO results.
- Accepts MULT/DIV requests from the execute stage, pulses start to the unit, and counts its latency.
- Raises the HI/LO write strobe, which travels down the pipeline registers, at completion.
- Stalls the pipeline while a dependent instruction (MFHI/MFLO/MTHI/MTLO or another MULT/DIV) would otherwise race the in-flight operation.

Parameters:
MULT_CYCLES, 4, multiply latency in RUN cycles; legal range is 1 or more.
DIV_CYCLES, 32, divide latency in RUN cycles; legal range is 1 or more.
CNT_W, 6, counter width; 2^CNT_W must exceed max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
mult_request_execute  in  1  MULT/MULTU is in the execute stage
div_request_execute  in  1  DIV/DIVU is in the execute stage
hi_lo_read_decode  in  1  MFHI/MFLO is in the decode stage
hi_lo_write_direct_decode  in  1  MTHI/MTLO is in the decode stage
flush_execute  in  1  the execute-stage instruction is being flushed this cycle
abort  in  1  exception; cancels the in-flight operation
unit_start  out  1  one-cycle start pulse to the mult/div datapath
unit_select_div  out  1  0 = multiply, 1 = divide; held stable while busy
hi_lo_register_write_unit  out  1  one-cycle HI/LO write strobe
stall_pipeline  out  1  freezes the fetch, decode and execute pipeline registers
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - unit_start=0, unit_select_div=0, hi_lo_register_write_unit=0, busy=0.
  - stall_pipeline=0 (busy=0 forces it low).
- States: IDLE, RUN, DONE. All outputs except stall_pipeline are registered.
- IDLE:
  - On a clock edge with (mult_request_execute | div_request_execute) & ~flush_execute & ~abort, go to RUN.
  - At that edge:
    - unit_select_div <= div_request_execute (divide wins if both are set).
    - counter <= cycles-1, where cycles = DIV_CYCLES if divide else MULT_CYCLES.
    - unit_start <= 1.
  - A request accompanied by flush_execute or abort is ignored: the machine stays in IDLE.
- RUN:
  - unit_start is high only in the first RUN cycle.
  - Counter decrements each cycle.
  - If counter==0 at an edge, go to DONE and hi_lo_register_write_unit <= 1.
  - Total RUN cycles = MULT_CYCLES or DIV_CYCLES exactly.
  - With MULT_CYCLES=1: RUN lasts one cycle, and unit_start and counter==0 coincide.
- DONE:
  - hi_lo_register_write_unit is high for exactly one cycle.
  - Next edge returns to IDLE.
  - A new request cannot be accepted in DONE; it is accepted on the following IDLE edge.
- Latency: request sampled at edge k → unit_start high in cycle k+1 → write strobe high in cycle k+N+1 → busy falls at edge k+N+2.
- abort (sampled at the edge):
  - In RUN or DONE, go to IDLE.
  - hi_lo_register_write_unit is forced to 0 at that edge, so no HI/LO write occurs; the counter is cleared.
  - abort takes priority over counter expiry.
- flush_execute has no effect once the machine is in RUN; the operation was issued by an older instruction.
- stall_pipeline (combinational) = busy & (hi_lo_read_decode | hi_lo_write_direct_decode | mult_request_execute | div_request_execute).
- A request held in execute by a stall re-presents itself and is accepted on the first IDLE edge.
- Asynchronous reset mid-RUN: immediate return to IDLE with all outputs low; the unit's result is discarded.

Optional Feature:
EARLY_HILO_RELEASE_EN
- Defined: in DONE, hi_lo_read_decode and hi_lo_write_direct_decode do not stall. The HI/LO forwarding path supplies the result, so the dependent instruction gains 1 cycle. Requests from mult_request_execute and div_request_execute still stall in DONE.
- Undefined: stall_pipeline follows the base equation in all non-IDLE states, including DONE.

Test Plan:
- Reset deassert, then mult_request_execute=1 for 1 cycle (MULT_CYCLES=4) → unit_start high in cycle 1, unit_select_div=0, write strobe high in cycle 5 only, busy low from cycle 6.
- div_request_execute=1 (DIV_CYCLES=32), then hi_lo_read_decode=1 held → stall_pipeline=1 in cycles 1..32 and in cycle 33 (DONE); with EARLY_HILO_RELEASE_EN defined, stall_pipeline=0 in cycle 33.
- mult_request_execute=1 and div_request_execute=1 in the same cycle → unit_select_div=1, write strobe in cycle 33.
- mult_request_execute=1 with flush_execute=1 → state stays IDLE, unit_start=0, no write strobe for 10 cycles.
- Divide started, abort=1 at cycle 10 → busy=0 in cycle 11, no write strobe ever; a new mult at cycle 12 completes normally with write in cycle 17.
- reset pulled low asynchronously mid-RUN (between edges) → all outputs 0 immediately; after release, a new mult yields its write strobe exactly 5 cycles after acceptance.
